// File: rtl/botassium_stream_mem_loader.sv
// Byte-stream to 32-bit RAM loader: packs bytes little-endian and writes each word from base_addr upward.
// Optional BOTASSIUM_LOADER_CHECKSUM_EN adds a 16-bit wrapping sum of the bytes accepted in FILL.
module botassium_stream_mem_loader #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 5000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   words_written
`ifdef BOTASSIUM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        pack_q;
  logic [3:0]         be_q;
  logic [1:0]         idx_q;
  logic               overflow_q;
  logic [ADDR_W:0]    cnt_q;
  logic               clken_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [31:0]        wr_data_q;
  logic [3:0]         wr_be_q;

  logic               accept;
  logic               complete;
  logic               commit;
  logic               drop;
  logic               in_range;
  logic               start_ok;
  logic [31:0]        word_full;
  logic [3:0]         be_full;

  assign s_ready   = (state_q == S_FILL) || (state_q == S_DRAIN);
  assign accept    = s_valid && s_ready;
  assign in_range  = addr_q < DEPTH_A;
  assign start_ok  = (state_q == S_IDLE) && start;
  assign word_full = pack_q | ({24'd0, s_data} << {idx_q, 3'b000});
  assign be_full   = be_q | (4'b0001 << idx_q);
  assign complete  = accept && (state_q == S_FILL) && ((idx_q == 2'd3) || s_last);
  assign commit    = complete && in_range;
  assign drop      = complete && !in_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (base_addr >= DEPTH_A) ? S_DRAIN : S_FILL;
        end
      end
      S_FILL: begin
        if (commit) begin
          state_d = s_last ? S_FLUSH : S_FILL;
        end else if (drop) begin
          state_d = s_last ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept && s_last) begin
          state_d = S_DONE;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Completed words are copied into the write registers so the pack register
  // can restart on the very next byte without stalling the stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      pack_q     <= '0;
      be_q       <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      clken_q    <= 1'b0;
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
    end else begin
      clken_q <= 1'b1;
      wr_q    <= commit;
      if (commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= word_full;
        wr_be_q   <= be_full;
        addr_q    <= addr_q + ADDR_W'(1);
      end
      if (wr_q) begin
        cnt_q <= cnt_q + (ADDR_W + 1)'(1);
      end
      if (accept && (state_q == S_FILL)) begin
        if (complete) begin
          pack_q <= '0;
          be_q   <= '0;
          idx_q  <= '0;
        end else begin
          pack_q <= word_full;
          be_q   <= be_full;
          idx_q  <= idx_q + 2'd1;
        end
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (start_ok) begin
        addr_q     <= base_addr;
        pack_q     <= '0;
        be_q       <= '0;
        idx_q      <= '0;
        overflow_q <= (base_addr >= DEPTH_A);
        cnt_q      <= '0;
      end
    end
  end

`ifdef BOTASSIUM_LOADER_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (accept && (state_q == S_FILL)) begin
      csum_q <= csum_q + {8'd0, s_data};
    end
  end

  assign checksum = csum_q;
`endif

  assign mem_write      = wr_q;
  assign mem_chipselect = wr_q;
  assign mem_address    = wr_addr_q;
  assign mem_writedata  = wr_data_q;
  assign mem_byteenable = wr_be_q;
  assign mem_clken      = clken_q;
  assign busy           = (state_q == S_FILL) || (state_q == S_DRAIN) || (state_q == S_FLUSH);
  assign done           = (state_q == S_DONE);
  assign overflow       = overflow_q;
  assign words_written  = cnt_q;

endmodule
